fp_mul_pipe: RTL
================

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 5, meaning exponent field width.
REQ-002 SHALL have parameter MAN_W, default 10, meaning stored mantissa field width (hidden bit excluded).
REQ-003 SHALL have parameter TAG_W, default 4, meaning width of the sideband tag carried alongside each operation.
REQ-004 SHALL have localparams W=1+EXP_W+MAN_W and BIAS=2^(EXP_W-1)-1.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clock  in  1  rising-edge clock for all state.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 in_valid  in  1  operand pair and tag present.
REQ-009 in_ready  out  1  block accepts an operation this cycle.
REQ-010 opA, opB  in  W each  operands {sign, exp, mantissa}.
REQ-011 in_tag  in  TAG_W  sideband tag, returned unchanged.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  consumer accepts the result this cycle.
REQ-014 product  out  W  rounded product.
REQ-015 out_tag  out  TAG_W  tag of the result.
REQ-016 flags  out  3  {overflow, underflow, inexact}.

Function
REQ-017 SHALL be a 3-stage pipeline: S1 unpack, classify, mantissa multiply and exponent sum; S2 normalise; S3 round, saturate, pack.
- Latency: exactly 3 cycles from an accepted input to out_valid when no stall occurs.
REQ-018 SHALL accept an input when in_valid && in_ready.
REQ-019 SHALL present a result when out_valid; the result is consumed when out_valid && out_ready.
REQ-020 SHALL drive in_ready = !(out_valid && !out_ready).
- When in_ready is low, the stall is global: every stage register holds.
- Bubbles are not collapsed.
REQ-021 SHALL hold product, out_tag and flags stable while out_valid && !out_ready.
REQ-022 SHALL sustain one operation per cycle when out_ready is held high.
REQ-023 SHALL form the significand product as {1,mA}*{1,mB}, 2*MAN_W+2 bits, with no truncation before rounding.
REQ-024 SHALL compute the exponent as eA+eB-BIAS in a signed EXP_W+2-bit width.
REQ-025 SHALL normalise when the product MSB is set: shift right by 1 and increment the exponent.
REQ-026 SHALL round to nearest, ties to even.
- Round bits: guard = first bit below the LSB; sticky = OR of all lower bits.
- On mantissa carry-out, increment the exponent and clear the mantissa.
REQ-027 SHALL set inexact when guard|sticky is set for a finite, non-special result.
REQ-028 SHALL treat an operand with exp==0 as signed zero (subnormal inputs are flushed).
- A zero operand gives result {sA^sB, 0, 0} and flags 0.
REQ-029 SHALL treat an operand with exp==all-ones as infinity.
- inf times non-zero gives {sA^sB, all-ones, 0} with flags 0.
- inf times zero gives canonical NaN {0, all-ones, 1 followed by zeros} with flags 0.
REQ-030 SHALL handle overflow when the final exponent is >= 2^EXP_W-1: result {sign, all-ones, 0}, overflow=1, inexact=1.
REQ-031 SHALL handle underflow when the final exponent is <= 0: result {sign, 0, 0}, underflow=1, inexact=1.
REQ-032 SHALL compute the result sign as sA^sB in all cases, NaN excepted.

Reset
REQ-033 SHALL, while reset_n is low, asynchronously clear all stage valid bits, out_valid, product, out_tag and flags to 0.
REQ-034 SHALL discard in-flight operations when reset is asserted mid-operation.
- in_ready reads 1 immediately after reset.
- The first result after reset release is the first operation accepted after release.

Verification
REQ-035 SHALL pass these directed scenarios (defaults EXP_W=5, MAN_W=10):
- Basic: 0x3C00*0x3C00 -> product 0x3C00, flags 000, out_valid exactly 3 cycles after acceptance.
- Normalise and tie rounding:
  - 0x3E00*0x3E00 -> 0x4080, flags 000.
  - 0x3C01*0x3E00 -> 0x3E02, inexact=1 (tie, round up to even).
  - 0x3C01*0x3C01 -> 0x3C02, inexact=1.
- Saturation:
  - 0x7800*0x4000 -> 0x7C00, flags 101.
  - 0x0400*0x3800 -> 0x0000, flags 011.
  - 0x8400*0x3800 -> 0x8000, flags 011.
- Specials:
  - 0x0000*0x7BFF -> 0x0000.
  - 0x7C00*0xC000 -> 0xFC00.
  - 0x7C00*0x0000 -> 0x7E00, flags 000.
- Backpressure: issue 4 back-to-back ops, then hold out_ready low 5 cycles.
  - in_ready goes low and outputs stay stable.
  - All 4 results and tags appear in order once out_ready rises; none lost or duplicated.
- Reset mid-flight: assert reset_n low with 3 ops in flight.
  - out_valid=0, product=0, flags=0 immediately.
  - No stale result appears after release.

Source files
------------

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage pipelined floating-point multiplier.
// Stage 1 unpacks and classifies both operands, multiplies the significands
// and sums the exponents. Stage 2 normalises the significand product.
// Stage 3 rounds to nearest-even, saturates and packs the result.
// A full output register that the consumer is not draining stalls every stage.
module fp_mul_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int TAG_W = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] opA,
    input  logic [EXP_W+MAN_W:0] opB,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] product,
    output logic [TAG_W-1:0]     out_tag,
    output logic [2:0]           flags
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int PW   = 2 * MAN_W + 2;
    localparam int XW   = EXP_W + 2;

    localparam logic signed [XW-1:0] BIAS_X    = XW'(BIAS);
    localparam logic signed [XW-1:0] EXP_MAX_X = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] ONE_X     = XW'(1);
    localparam logic signed [XW-1:0] ZERO_X    = XW'(0);
    localparam logic [EXP_W-1:0]     EXP_ONES  = '1;

    // Operand class travels down the pipe so specials bypass rounding.
    localparam logic [1:0] CLS_NORM = 2'd0;
    localparam logic [1:0] CLS_ZERO = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NAN  = 2'd3;

    // Unpacked operand fields
    logic                     a_sign, b_sign;
    logic [EXP_W-1:0]         a_exp, b_exp;
    logic [MAN_W-1:0]         a_man, b_man;

    // Stage 1 combinational results
    logic                     a_zero, b_zero, a_inf, b_inf;
    logic [1:0]               cls_c;
    logic [PW-1:0]            sig_prod_c;
    logic signed [XW-1:0]     exp_sum_c;

    // Stage 1 registers
    logic                     s1_valid_d, s1_valid_q;
    logic                     s1_sign_d, s1_sign_q;
    logic [1:0]               s1_cls_d, s1_cls_q;
    logic signed [XW-1:0]     s1_exp_d, s1_exp_q;
    logic [PW-1:0]            s1_sig_d, s1_sig_q;
    logic [TAG_W-1:0]         s1_tag_d, s1_tag_q;

    // Stage 2 combinational results
    logic signed [XW-1:0]     norm_exp_c;
    logic [MAN_W-1:0]         norm_man_c;
    logic                     norm_guard_c, norm_sticky_c;

    // Stage 2 registers
    logic                     s2_valid_d, s2_valid_q;
    logic                     s2_sign_d, s2_sign_q;
    logic [1:0]               s2_cls_d, s2_cls_q;
    logic signed [XW-1:0]     s2_exp_d, s2_exp_q;
    logic [MAN_W-1:0]         s2_man_d, s2_man_q;
    logic                     s2_guard_d, s2_guard_q;
    logic                     s2_sticky_d, s2_sticky_q;
    logic [TAG_W-1:0]         s2_tag_d, s2_tag_q;

    // Stage 3 combinational results
    logic                     round_up_c;
    logic [MAN_W:0]           man_rnd_c;
    logic signed [XW-1:0]     exp_rnd_c;
    logic [W-1:0]             product_c;
    logic [2:0]               flags_c;

    // Output registers
    logic                     out_valid_d, out_valid_q;
    logic [W-1:0]             product_d, product_q;
    logic [TAG_W-1:0]         out_tag_d, out_tag_q;
    logic [2:0]               flags_d, flags_q;

    assign {a_sign, a_exp, a_man} = opA;
    assign {b_sign, b_exp, b_man} = opB;

    // A held result that is not being taken freezes the whole pipe.
    assign in_ready  = !(out_valid_q && !out_ready);

    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign out_tag   = out_tag_q;
    assign flags     = flags_q;

    // Stage 1: classify operands, form full-width significand product and biased exponent sum
    always_comb begin
        a_zero = (a_exp == '0);
        b_zero = (b_exp == '0);
        a_inf  = (a_exp == EXP_ONES);
        b_inf  = (b_exp == EXP_ONES);
        if ((a_inf || b_inf) && (a_zero || b_zero)) begin
            cls_c = CLS_NAN;
        end else if (a_inf || b_inf) begin
            cls_c = CLS_INF;
        end else if (a_zero || b_zero) begin
            cls_c = CLS_ZERO;
        end else begin
            cls_c = CLS_NORM;
        end
        sig_prod_c = PW'({1'b1, a_man}) * PW'({1'b1, b_man});
        exp_sum_c  = $signed(XW'(a_exp)) + $signed(XW'(b_exp)) - BIAS_X;
    end

    // Stage 1 register next-state: load a new operation (or bubble) unless stalled
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_cls_d   = s1_cls_q;
        s1_exp_d   = s1_exp_q;
        s1_sig_d   = s1_sig_q;
        s1_tag_d   = s1_tag_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            s1_sign_d  = a_sign ^ b_sign;
            s1_cls_d   = cls_c;
            s1_exp_d   = exp_sum_c;
            s1_sig_d   = sig_prod_c;
            s1_tag_d   = in_tag;
        end
    end

    // Stage 2: normalise so the hidden bit sits on top, keeping every dropped bit for rounding
    always_comb begin
        norm_exp_c    = s1_exp_q;
        norm_man_c    = s1_sig_q[PW-3 -: MAN_W];
        norm_guard_c  = s1_sig_q[MAN_W-1];
        norm_sticky_c = |s1_sig_q[MAN_W-2:0];
        if (s1_sig_q[PW-1]) begin
            norm_exp_c    = s1_exp_q + ONE_X;
            norm_man_c    = s1_sig_q[PW-2 -: MAN_W];
            norm_guard_c  = s1_sig_q[MAN_W];
            norm_sticky_c = |s1_sig_q[MAN_W-1:0];
        end
    end

    // Stage 2 register next-state: advance stage 1 contents unless stalled
    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_sign_d   = s2_sign_q;
        s2_cls_d    = s2_cls_q;
        s2_exp_d    = s2_exp_q;
        s2_man_d    = s2_man_q;
        s2_guard_d  = s2_guard_q;
        s2_sticky_d = s2_sticky_q;
        s2_tag_d    = s2_tag_q;
        if (in_ready) begin
            s2_valid_d  = s1_valid_q;
            s2_sign_d   = s1_sign_q;
            s2_cls_d    = s1_cls_q;
            s2_exp_d    = norm_exp_c;
            s2_man_d    = norm_man_c;
            s2_guard_d  = norm_guard_c;
            s2_sticky_d = norm_sticky_c;
            s2_tag_d    = s1_tag_q;
        end
    end

    // Stage 3: round to nearest-even, then saturate or substitute special results and pack
    always_comb begin
        round_up_c = s2_guard_q & (s2_sticky_q | s2_man_q[0]);
        man_rnd_c  = {1'b0, s2_man_q} + (MAN_W+1)'(round_up_c);
        exp_rnd_c  = s2_exp_q + (man_rnd_c[MAN_W] ? ONE_X : ZERO_X);
        product_c  = {s2_sign_q, exp_rnd_c[EXP_W-1:0], man_rnd_c[MAN_W-1:0]};
        flags_c    = {2'b00, s2_guard_q | s2_sticky_q};
        case (s2_cls_q)
            CLS_ZERO: begin
                product_c = {s2_sign_q, {(W-1){1'b0}}};
                flags_c   = 3'b000;
            end
            CLS_INF: begin
                product_c = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
                flags_c   = 3'b000;
            end
            CLS_NAN: begin
                product_c = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
                flags_c   = 3'b000;
            end
            default: begin
                if (exp_rnd_c >= EXP_MAX_X) begin
                    product_c = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
                    flags_c   = 3'b101;
                end else if (exp_rnd_c <= ZERO_X) begin
                    product_c = {s2_sign_q, {(W-1){1'b0}}};
                    flags_c   = 3'b011;
                end
            end
        endcase
    end

    // Output register next-state: capture stage 3 result unless the consumer is holding it
    always_comb begin
        out_valid_d = out_valid_q;
        product_d   = product_q;
        out_tag_d   = out_tag_q;
        flags_d     = flags_q;
        if (in_ready) begin
            out_valid_d = s2_valid_q;
            product_d   = product_c;
            out_tag_d   = s2_tag_q;
            flags_d     = flags_c;
        end
    end

    // All pipeline state; reset empties the pipe and clears the visible outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_cls_q    <= CLS_NORM;
            s1_exp_q    <= ZERO_X;
            s1_sig_q    <= '0;
            s1_tag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_cls_q    <= CLS_NORM;
            s2_exp_q    <= ZERO_X;
            s2_man_q    <= '0;
            s2_guard_q  <= 1'b0;
            s2_sticky_q <= 1'b0;
            s2_tag_q    <= '0;
            out_valid_q <= 1'b0;
            product_q   <= '0;
            out_tag_q   <= '0;
            flags_q     <= 3'b000;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_cls_q    <= s1_cls_d;
            s1_exp_q    <= s1_exp_d;
            s1_sig_q    <= s1_sig_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_sign_q   <= s2_sign_d;
            s2_cls_q    <= s2_cls_d;
            s2_exp_q    <= s2_exp_d;
            s2_man_q    <= s2_man_d;
            s2_guard_q  <= s2_guard_d;
            s2_sticky_q <= s2_sticky_d;
            s2_tag_q    <= s2_tag_d;
            out_valid_q <= out_valid_d;
            product_q   <= product_d;
            out_tag_q   <= out_tag_d;
            flags_q     <= flags_d;
        end
    end

endmodule
